vz_image_loader: RTL and testbench

//  Consumes the HPS ioctl download stream for VZ images (index IMG_INDEX) and turns it into

---
 rtl/vz_image_loader.sv | 198 +++++++++++++++++++
 tb/tb_vz_image_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vz_image_loader.sv
// VZ image loader: parses the VZ header from the ioctl stream, buffers payload in a FIFO
// and writes guest RAM over req/ack while the Z80 is held; then patches BASIC end or execs.
// Ports: CLK10MHZ, RESET (async, active-low); dn_* ioctl download input;
//   ram_req/ram_addr/ram_data/ram_ack RAM write port; cpu_hold Z80 BUSRQ;
//   exec_valid/exec_addr binary entry point; load_done/load_err status of last session.
module vz_image_loader #(
    parameter logic [7:0]  IMG_INDEX  = 8'd1,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] PTR_ADDR   = 16'h78F9
) (
    input  logic        CLK10MHZ,
    input  logic        RESET,
    input  logic        dn_download,
    input  logic [7:0]  dn_index,
    input  logic        dn_wr,
    input  logic [15:0] dn_addr,
    input  logic [7:0]  dn_data,
    output logic        ram_req,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_data,
    input  logic        ram_ack,
    output logic        cpu_hold,
    output logic        exec_valid,
    output logic [15:0] exec_addr,
    output logic        load_done,
    output logic        load_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_DATA, S_FLUSH, S_PTR_LO, S_PTR_HI, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          err_q, err_d;
    logic          done_q, hold_q, exv_q;
    logic [15:0]   exa_q, start_q, len_q;
    logic [7:0]    type_q;
    logic          mag_a_q, mag_b_q;
    logic [23:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;

    logic        session, wr_ok, hdr_wr, data_wr;
    logic        empty, full, push, pop, mag_fail;
    logic        mag_a_d, mag_b_d, start_sess, exec_fire;
    logic [15:0] ptr_val;

    function automatic logic [7:0] magic_a(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h56;
            2'd1:    return 8'h5A;
            2'd2:    return 8'h46;
            default: return 8'h30;
        endcase
    endfunction

    function automatic logic [7:0] magic_b(input logic [1:0] i);
        return (i < 2'd2) ? 8'h20 : 8'h00;
    endfunction

    assign session = dn_download && (dn_index == IMG_INDEX);
    assign wr_ok   = dn_wr && session;
    // once the magic has failed, the rest of the header is ignored
    assign hdr_wr  = wr_ok && (state_q == S_HDR) && !err_q
                     && (dn_addr < 16'd24);
    assign data_wr = wr_ok && (state_q == S_DATA) && (dn_addr >= 16'd24);
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    assign pop     = ram_ack && !empty;
    // a pop in the same cycle frees the slot, so full+pop still accepts
    assign push    = data_wr && (!full || pop);
    assign ptr_val = start_q + len_q;

    // both accepted magic patterns are tracked in parallel
    assign mag_a_d  = mag_a_q && (dn_data == magic_a(dn_addr[1:0]));
    assign mag_b_d  = mag_b_q && (dn_data == magic_b(dn_addr[1:0]));
    assign mag_fail = hdr_wr && (dn_addr == 16'd3) && !mag_a_d && !mag_b_d;

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        start_sess = 1'b0;
        exec_fire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (session) begin
                    state_d    = S_HDR;
                    start_sess = 1'b1;
                end
            end
            S_HDR: begin
                if (!session) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (hdr_wr && (dn_addr == 16'd23)) begin
                    state_d = S_DATA;
                end
            end
            S_DATA:  if (!session) state_d = S_FLUSH;
            S_FLUSH: begin
                if (empty) begin
                    if (type_q == 8'hF0) begin
                        state_d = S_PTR_LO;
                    end else begin
                        exec_fire = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end
            S_PTR_LO: if (ram_ack) state_d = S_PTR_HI;
            S_PTR_HI: if (ram_ack) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (mag_fail || (data_wr && !push)) err_d = 1'b1;
        if (start_sess) err_d = 1'b0;
    end

    always_comb begin
        ram_req  = !empty;
        ram_addr = empty ? 16'h0000 : mem_q[rp_q][23:8];
        ram_data = empty ? 8'h00 : mem_q[rp_q][7:0];
        if (state_q == S_PTR_LO) begin
            ram_req  = 1'b1;
            ram_addr = PTR_ADDR;
            ram_data = ptr_val[7:0];
        end else if (state_q == S_PTR_HI) begin
            ram_req  = 1'b1;
            ram_addr = PTR_ADDR + 16'd1;
            ram_data = ptr_val[15:8];
        end
    end

    always_ff @(posedge CLK10MHZ or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= 1'b0;
            exv_q   <= 1'b0;
            exa_q   <= 16'h0000;
            start_q <= 16'h0000;
            len_q   <= 16'h0000;
            type_q  <= 8'h00;
            mag_a_q <= 1'b1;
            mag_b_q <= 1'b1;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            hold_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
            exv_q   <= exec_fire;
            if (exec_fire) exa_q <= start_q;
            if (start_sess) begin
                done_q  <= 1'b0;
                start_q <= 16'h0000;
                len_q   <= 16'h0000;
                type_q  <= 8'h00;
                mag_a_q <= 1'b1;
                mag_b_q <= 1'b1;
                wp_q    <= '0;
                rp_q    <= '0;
                cnt_q   <= '0;
            end else begin
                if ((state_d == S_DONE) && (state_q != S_DONE))
                    done_q <= !err_d;
                if (hdr_wr) begin
                    if (dn_addr < 16'd4) begin
                        mag_a_q <= mag_a_d;
                        mag_b_q <= mag_b_d;
                    end
                    if (dn_addr == 16'd21) type_q <= dn_data;
                    if (dn_addr == 16'd22) start_q[7:0] <= dn_data;
                    if (dn_addr == 16'd23) start_q[15:8] <= dn_data;
                end
                if (data_wr) len_q <= len_q + 16'd1;
                if (push) wp_q <= wp_q + AW'(1);
                if (pop)  rp_q <= rp_q + AW'(1);
                cnt_q <= cnt_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge CLK10MHZ) begin
        if (push) mem_q[wp_q] <= {start_q + dn_addr - 16'd24, dn_data};
    end

    assign cpu_hold   = hold_q;
    assign exec_valid = exv_q;
    assign exec_addr  = exa_q;
    assign load_done  = done_q;
    assign load_err   = err_q;
endmodule

// File: tb/tb_vz_image_loader.sv
// Bench for vz_image_loader: directed and random VZ images checked against
// a write-list model built from the file contents.
module tb_vz_image_loader;
    typedef logic [7:0]  bq_t[$];
    typedef logic [23:0] wq_t[$];

    localparam int FIFO = 4;
    localparam logic [31:0] VZF0 = 32'h565A4630;
    localparam logic [31:0] SPC0 = 32'h20200000;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        dn_download = 1'b0;
    logic [7:0]  dn_index = 8'h00;
    logic        dn_wr = 1'b0;
    logic [15:0] dn_addr = 16'h0000;
    logic [7:0]  dn_data = 8'h00;
    logic        ram_ack = 1'b0;
    logic        ram_req, cpu_hold, exec_valid, load_done, load_err;
    logic [15:0] ram_addr, exec_addr;
    logic [7:0]  ram_data;

    int tests = 0;
    int fails = 0;
    int ack_mode = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    wq_t got;
    int exec_cnt = 0;
    logic [15:0] exec_seen = 16'h0000;
    logic hold_seen = 1'b0;
    logic pend = 1'b0;
    logic [23:0] pend_val = 24'h0;

    always #50 clk = ~clk;

    vz_image_loader #(
        .IMG_INDEX(8'd1), .FIFO_DEPTH(FIFO), .PTR_ADDR(16'h78F9)
    ) dut (
        .CLK10MHZ(clk), .RESET(RESET), .dn_download(dn_download),
        .dn_index(dn_index), .dn_wr(dn_wr), .dn_addr(dn_addr),
        .dn_data(dn_data), .ram_req(ram_req), .ram_addr(ram_addr),
        .ram_data(ram_data), .ram_ack(ram_ack), .cpu_hold(cpu_hold),
        .exec_valid(exec_valid), .exec_addr(exec_addr),
        .load_done(load_done), .load_err(load_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RAM acknowledger: 0 = always ack, 1 = ack after ack_delay waits, 2 = stall
    initial forever begin
        @(posedge clk); #1;
        if (ack_mode == 0) begin
            ram_ack = 1'b1;
        end else if (ack_mode == 2) begin
            ram_ack = 1'b0;
            wait_cnt = 0;
        end else if (ram_req && wait_cnt >= ack_delay) begin
            ram_ack = 1'b1;
            wait_cnt = 0;
        end else begin
            ram_ack = 1'b0;
            if (ram_req) wait_cnt++;
        end
    end

    // monitor: collect accepted writes, check request stability while waiting
    always @(negedge clk) begin
        if (!RESET) begin
            pend = 1'b0;
        end else begin
            if (cpu_hold) hold_seen = 1'b1;
            if (exec_valid) begin
                exec_cnt++;
                exec_seen = exec_addr;
            end
            if (pend) begin
                chk("req_held", 32'(ram_req), 32'd1);
                chk("req_stable", 32'({ram_addr, ram_data}), 32'(pend_val));
            end
            if (ram_req && ram_ack) got.push_back({ram_addr, ram_data});
            pend = ram_req && !ram_ack;
            pend_val = {ram_addr, ram_data};
        end
    end

    function automatic bq_t mk(input logic [31:0] magic, input logic [7:0] typ,
                               input logic [15:0] start, input bq_t pay);
        bq_t f;
        for (int i = 0; i < 24; i++) f.push_back(8'($urandom));
        f[0] = magic[31:24];
        f[1] = magic[23:16];
        f[2] = magic[15:8];
        f[3] = magic[7:0];
        f[21] = typ;
        f[22] = start[7:0];
        f[23] = start[15:8];
        foreach (pay[i]) f.push_back(pay[i]);
        return f;
    endfunction

    task automatic load(input logic [7:0] idx, input bq_t f, input int gap,
                        input bit keep_open);
        @(posedge clk); #1;
        dn_index = idx;
        dn_download = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < f.size(); i++) begin
            dn_wr = 1'b1;
            dn_addr = 16'(i);
            dn_data = f[i];
            @(posedge clk); #1;
            dn_wr = 1'b0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
        if (!keep_open) dn_download = 1'b0;
    endtask

    task automatic finish_wait(input string tag);
        int n = 0;
        while ((cpu_hold !== 1'b0 || ram_req !== 1'b0) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < 2000), 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_case(input string tag, input logic [31:0] magic,
                            input logic [7:0] typ, input logic [15:0] start,
                            input int n, input int trunc, input int gap,
                            input int mode, input int dly);
        bq_t pay;
        bq_t f;
        wq_t exp;
        bit hdr_ok;
        bit exp_err;
        int keep;
        logic [15:0] endp;
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
        f = mk(magic, typ, start, pay);
        while (trunc > 0 && f.size() > trunc) void'(f.pop_back());
        hdr_ok = (magic == VZF0 || magic == SPC0) && f.size() >= 24;
        // a stalled RAM port lets only FIFO-full worth of bytes in
        keep = (mode == 2 && n > FIFO) ? FIFO : n;
        exp_err = !hdr_ok || keep < n;
        if (hdr_ok) begin
            for (int i = 0; i < keep; i++)
                exp.push_back({start + 16'(i), pay[i]});
            if (typ == 8'hF0) begin
                endp = start + 16'(n);
                exp.push_back({16'h78F9, endp[7:0]});
                exp.push_back({16'h78FA, endp[15:8]});
            end
        end
        got.delete();
        exec_cnt = 0;
        hold_seen = 1'b0;
        ack_mode = mode;
        ack_delay = dly;
        load(8'd1, f, gap, 1'b0);
        if (mode == 2) begin
            repeat (20) begin
                @(posedge clk); #1;
            end
            ack_mode = 0;
        end
        finish_wait(tag);
        chk({tag, "_nwr"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk({tag, "_wr"}, 32'(got[i]), 32'(exp[i]));
        chk({tag, "_err"}, 32'(load_err), 32'(exp_err));
        chk({tag, "_done"}, 32'(load_done), 32'(!exp_err));
        chk({tag, "_hold_off"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_hold_seen"}, 32'(hold_seen), 32'd1);
        chk({tag, "_exec_n"}, 32'(exec_cnt), 32'(hdr_ok && typ != 8'hF0));
        if (hdr_ok && typ != 8'hF0)
            chk({tag, "_exec_addr"}, 32'(exec_seen), 32'(start));
    endtask

    initial begin
        bq_t f;
        bq_t pay;
        bq_t rom;
        logic d0, e0;
        int pick;
        logic [7:0] typ;

        #10 RESET = 1'b0;
        #30;
        chk("rst_req", 32'(ram_req), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_exec", 32'(exec_valid), 32'd0);
        chk("rst_exec_addr", 32'(exec_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1 RESET = 1'b1;

        run_case("f0_basic", VZF0, 8'hF0, 16'h7AE9, 5, 0, 0, 0, 0);
        run_case("f1_slow", VZF0, 8'hF1, 16'h8000, 3, 0, 5, 1, 3);
        run_case("overflow", VZF0, 8'hF1, 16'h4000, 6, 0, 0, 2, 0);
        run_case("bad_magic", 32'h41424344, 8'hF0, 16'h7AE9, 3, 0, 0, 0, 0);
        run_case("short", VZF0, 8'hF0, 16'h7AE9, 0, 10, 0, 0, 0);
        run_case("wrap", SPC0, 8'hF0, 16'hFFFE, 4, 0, 0, 0, 0);

        for (int k = 0; k < 6; k++) begin
            pick = int'($urandom_range(0, 2));
            typ = (pick == 0) ? 8'hF0 : (pick == 1) ? 8'hF1 : 8'($urandom);
            run_case("rand", ($urandom_range(0, 1) == 0) ? VZF0 : SPC0, typ,
                     16'($urandom), int'($urandom_range(0, 8)), 0, 5, 1,
                     int'($urandom_range(0, 3)));
        end

        // ROM download on another index leaves everything alone
        d0 = load_done;
        e0 = load_err;
        got.delete();
        hold_seen = 1'b0;
        exec_cnt = 0;
        for (int i = 0; i < 40; i++) rom.push_back(8'($urandom));
        load(8'd0, rom, 0, 1'b0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("rom_nwr", 32'(got.size()), 32'd0);
        chk("rom_hold", 32'(hold_seen), 32'd0);
        chk("rom_done", 32'(load_done), 32'(d0));
        chk("rom_err", 32'(load_err), 32'(e0));
        chk("rom_exec", 32'(exec_cnt), 32'd0);

        // reset in the middle of the payload aborts the load
        ack_mode = 2;
        got.delete();
        for (int i = 0; i < 3; i++) pay.push_back(8'($urandom));
        f = mk(VZF0, 8'hF0, 16'h9000, pay);
        load(8'd1, f, 0, 1'b1);
        chk("mid_req", 32'(ram_req), 32'd1);
        chk("mid_hold", 32'(cpu_hold), 32'd1);
        #20 RESET = 1'b0;
        #1;
        chk("arst_req", 32'(ram_req), 32'd0);
        chk("arst_hold", 32'(cpu_hold), 32'd0);
        chk("arst_done", 32'(load_done), 32'd0);
        chk("arst_err", 32'(load_err), 32'd0);
        dn_download = 1'b0;
        ack_mode = 0;
        @(posedge clk); #1;
        RESET = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("arst_nwr", 32'(got.size()), 32'd0);
        chk("arst_hold_after", 32'(cpu_hold), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
